norm_shifter: RTL and testbench
===============================

NORM_SHIFTER -- requirements
Module: norm_shifter

Interface
REQ-001 SHALL have parameter SWR, default 26, meaning significand working width (55 for DOUBLE build).
REQ-002 SHALL have parameter EWR, default 5, meaning shift-amount width (6 for DOUBLE build).
REQ-003 SHALL have parameter EW, default 8, meaning exponent width (11 for DOUBLE build).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  input  1  request a normalization of the current operands.
REQ-007 SHALL have port Data_i  input  SWR  unnormalized add/subtract result.
REQ-008 SHALL have port Shift_Value_i  input  EWR  leading-zero count produced by the LZD.
REQ-009 SHALL have port Exp_i  input  EW  exponent before normalization.
REQ-010 SHALL have port Data_o  output  SWR  left-shifted (normalized) significand.
REQ-011 SHALL have port Exp_o  output  EW  adjusted exponent.
REQ-012 SHALL have port underflow_o  output  1  exponent adjustment went below zero.
REQ-013 SHALL have port zero_o  output  1  Data_i was all-zero.
REQ-014 SHALL have port busy_o  output  1  operation in progress, start_i ignored.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse, results valid.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 In IDLE with start_i=1, SHALL capture Data_i, Shift_Value_i, Exp_i and go to SHIFT; stage counter = 0.
REQ-018 In SHIFT, cycle k (k=0..EWR-1), SHALL shift working register left by 2^k, zero-filling, when captured shift bit k = 1; else hold.
REQ-019 After stage EWR-1, SHALL go to DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-020 done_o SHALL be 1 only in DONE; latency start_i sample edge to done_o = EWR+1 cycles (6 for SINGLE).
REQ-021 busy_o SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-022 start_i SHALL be ignored while busy_o=1; a start_i in the DONE cycle SHALL NOT be accepted.
REQ-023 Data_o, Exp_o, underflow_o, zero_o SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-024 Exp_o SHALL equal Exp_i - Shift_Value_i (zero-extended) when Shift_Value_i <= Exp_i.
REQ-025 When Shift_Value_i > Exp_i, SHALL set underflow_o=1 and Exp_o=0; Data_o still the full shifted value.
REQ-026 Shift amounts >= SWR SHALL produce Data_o = 0 (no wrap-around of shifted bits).
REQ-027 When captured Data_i = 0, SHALL set zero_o=1, Data_o=0, Exp_o=0, underflow_o=0 regardless of Shift_Value_i.
REQ-028 Shift_Value_i = 0 SHALL pass Data_i and Exp_i unchanged, same latency.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, stage counter 0, and all outputs to 0, including mid-SHIFT or in DONE.
REQ-030 rst SHALL take priority over start_i in the same cycle; no done_o for an aborted operation.

Structure
REQ-031 SHALL place FSM state encoding and the SINGLE/DOUBLE SWR/EWR/EW constant sets in a shared package used by the FPU add/sub path.
REQ-032 SHALL use one sub-module norm_shift_stage (conditional left shift by a parameterized amount, zero fill), instanced per-cycle with shift selected by stage counter.

Verification
REQ-033 Data_i=26'h0000001, Shift_Value_i=25, Exp_i=100, start_i pulse -> done_o 6 cycles later, Data_o=26'h2000000, Exp_o=75, underflow_o=0.
REQ-034 Data_i=26'h0400000, Shift_Value_i=3, Exp_i=2 -> Data_o=26'h2000000, Exp_o=0, underflow_o=1.
REQ-035 Data_i=26'h3FFFFFF, Shift_Value_i=0, Exp_i=127 -> Data_o=26'h3FFFFFF, Exp_o=127, done_o at cycle 6.
REQ-036 Data_i=0, Shift_Value_i=31, Exp_i=50 -> zero_o=1, Data_o=0, Exp_o=0; separately Data_i=1, Shift_Value_i=31 -> Data_o=0.
REQ-037 Second start_i at cycles 2 and 6 of an operation -> ignored, exactly one done_o; start_i at cycle 7 accepted.
REQ-038 rst asserted at cycle 3 of SHIFT -> next cycle IDLE, all outputs 0, no done_o; following start completes normally.

Source files
------------

// File: rtl/norm_shifter_pkg.sv
// Shared constants and FSM encoding for the FPU add/sub normalization path.
package norm_shifter_pkg;

  localparam int unsigned SINGLE_SWR = 26;
  localparam int unsigned SINGLE_EWR = 5;
  localparam int unsigned SINGLE_EW  = 8;

  localparam int unsigned DOUBLE_SWR = 55;
  localparam int unsigned DOUBLE_EWR = 6;
  localparam int unsigned DOUBLE_EW  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

endpackage

// File: rtl/norm_shift_stage.sv
// Conditional left shift by a fixed amount with zero fill.
module norm_shift_stage #(
  parameter int unsigned W     = 26,
  parameter int unsigned SHIFT = 1
) (
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] shifted_c
);

  generate
    if (SHIFT >= W) begin : g_flush
      assign shifted_c = en ? '0 : data;
    end else begin : g_shift
      assign shifted_c = en ? {data[W-1-SHIFT:0], {SHIFT{1'b0}}} : data;
    end
  endgenerate

endmodule

// File: rtl/norm_shifter.sv
// Multi-cycle normalizing left shifter: one power-of-two stage per cycle,
// exponent adjusted by the leading-zero count with underflow clamp.
module norm_shifter
  import norm_shifter_pkg::*;
#(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5,
  parameter int unsigned EW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [SWR-1:0] Data_i,
  input  logic [EWR-1:0] Shift_Value_i,
  input  logic [EW-1:0]  Exp_i,
  output logic [SWR-1:0] Data_o,
  output logic [EW-1:0]  Exp_o,
  output logic           underflow_o,
  output logic           zero_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int unsigned CW = (EWR > 1) ? $clog2(EWR) : 1;

  norm_state_e    state;
  logic [CW-1:0]  cnt;
  logic [SWR-1:0] work;
  logic [EWR-1:0] shamt;
  logic [EW-1:0]  exp_q;
  logic           zero_q;

  logic [SWR-1:0] stage_c [EWR];
  logic [SWR-1:0] next_work_c;
  logic [EW:0]    exp_diff_c;

  // Stage k shifts by 2^k when bit k of the captured count is set.
  generate
    for (genvar k = 0; k < int'(EWR); k++) begin : g_stage
      norm_shift_stage #(
        .W     (SWR),
        .SHIFT (1 << k)
      ) u_stage (
        .en        (shamt[k]),
        .data      (work),
        .shifted_c (stage_c[k])
      );
    end
  endgenerate

  always_comb begin
    next_work_c = work;
    for (int k = 0; k < int'(EWR); k++) begin
      if (cnt == CW'(k)) next_work_c = stage_c[k];
    end
  end

  // Extra MSB of the difference is the borrow, i.e. underflow.
  assign exp_diff_c = {1'b0, exp_q} - {{(EW + 1 - EWR){1'b0}}, shamt};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      shamt       <= '0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
      Data_o      <= '0;
      Exp_o       <= '0;
      underflow_o <= 1'b0;
      zero_o      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            work   <= Data_i;
            shamt  <= Shift_Value_i;
            exp_q  <= Exp_i;
            zero_q <= (Data_i == '0);
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          work <= next_work_c;
          if (cnt == CW'(EWR - 1)) begin
            state  <= DONE;
            done_o <= 1'b1;
            Data_o <= next_work_c;
            zero_o <= zero_q;
            if (zero_q) begin
              Exp_o       <= '0;
              underflow_o <= 1'b0;
            end else if (exp_diff_c[EW]) begin
              Exp_o       <= '0;
              underflow_o <= 1'b1;
            end else begin
              Exp_o       <= exp_diff_c[EW-1:0];
              underflow_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_shifter.sv
// Directed bench for norm_shifter (SINGLE build): vector table plus
// hand sequences for overlapping starts and mid-operation reset.
module tb_norm_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [25:0] Data_i;
  logic [4:0]  Shift_Value_i;
  logic [7:0]  Exp_i;
  logic [25:0] Data_o;
  logic [7:0]  Exp_o;
  logic        underflow_o;
  logic        zero_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  norm_shifter #(.SWR(26), .EWR(5), .EW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .Data_i        (Data_i),
    .Shift_Value_i (Shift_Value_i),
    .Exp_i         (Exp_i),
    .Data_o        (Data_o),
    .Exp_o         (Exp_o),
    .underflow_o   (underflow_o),
    .zero_o        (zero_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] data;
    logic [4:0]  sh;
    logic [7:0]  exp;
    logic [25:0] r_data;
    logic [7:0]  r_exp;
    logic        r_uf;
    logic        r_zero;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Starts an operation and returns the cycle (1 = cycle after the sample edge) of done_o.
  task automatic run_op(input logic [25:0] d, input logic [4:0] s, input logic [7:0] e,
                        output int lat);
    @(negedge clk);
    Data_i = d; Shift_Value_i = s; Exp_i = e; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int dones;

    vecs[0] = '{26'h0000001, 5'd25, 8'd100, 26'h2000000, 8'd75,  1'b0, 1'b0};
    vecs[1] = '{26'h0400000, 5'd3,  8'd2,   26'h2000000, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{26'h3FFFFFF, 5'd0,  8'd127, 26'h3FFFFFF, 8'd127, 1'b0, 1'b0};
    vecs[3] = '{26'h0000000, 5'd31, 8'd50,  26'h0000000, 8'd0,   1'b0, 1'b1};
    vecs[4] = '{26'h0000001, 5'd31, 8'd10,  26'h0000000, 8'd0,   1'b1, 1'b0};
    vecs[5] = '{26'h0000ABC, 5'd4,  8'd20,  26'h000ABC0, 8'd16,  1'b0, 1'b0};
    vecs[6] = '{26'h1234567, 5'd8,  8'd8,   26'h3456700, 8'd0,   1'b0, 1'b0};
    vecs[7] = '{26'h2AAAAAA, 5'd1,  8'd1,   26'h1555554, 8'd0,   1'b0, 1'b0};
    vecs[8] = '{26'h0000001, 5'd26, 8'd200, 26'h0000000, 8'd174, 1'b0, 1'b0};

    rst = 1'b1; start_i = 1'b0; Data_i = '0; Shift_Value_i = '0; Exp_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset Data_o", 32'(Data_o), 32'd0);
    check("reset Exp_o", 32'(Exp_o), 32'd0);
    check("reset flags", {28'd0, underflow_o, zero_o, busy_o, done_o}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].data, vecs[i].sh, vecs[i].exp, lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'd6);
      check($sformatf("v%0d Data_o", i), 32'(Data_o), 32'(vecs[i].r_data));
      check($sformatf("v%0d Exp_o", i), 32'(Exp_o), 32'(vecs[i].r_exp));
      check($sformatf("v%0d underflow_o", i), 32'(underflow_o), 32'(vecs[i].r_uf));
      check($sformatf("v%0d zero_o", i), 32'(zero_o), 32'(vecs[i].r_zero));
      check($sformatf("v%0d busy in DONE", i), 32'(busy_o), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d done pulse width", i), 32'(done_o), 32'd0);
      check($sformatf("v%0d idle busy", i), 32'(busy_o), 32'd0);
      check($sformatf("v%0d Data_o hold", i), 32'(Data_o), 32'(vecs[i].r_data));
    end

    // Restarts at cycles 2 and 6 are ignored; the one held into cycle 7 is taken.
    @(negedge clk);
    Data_i = 26'h0000001; Shift_Value_i = 5'd25; Exp_i = 8'd100; start_i = 1'b1;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 1) check("ovl busy c1", 32'(busy_o), 32'd1);
      if (c == 2) begin
        Data_i = 26'h3FFFFFF; Shift_Value_i = 5'd0; Exp_i = 8'd127; start_i = 1'b1;
      end
      if (c == 6) begin
        check("ovl first done c6", 32'(done_o), 32'd1);
        check("ovl first Data_o", 32'(Data_o), 32'h2000000);
        check("ovl first Exp_o", 32'(Exp_o), 32'd75);
        Data_i = 26'h0000ABC; Shift_Value_i = 5'd4; Exp_i = 8'd20; start_i = 1'b1;
      end
      if (c == 7) begin
        check("ovl idle c7", 32'(busy_o), 32'd0);
        start_i = 1'b1;
      end
      if (c == 13) begin
        check("ovl second done c13", 32'(done_o), 32'd1);
        check("ovl second Data_o", 32'(Data_o), 32'h000ABC0);
        check("ovl second Exp_o", 32'(Exp_o), 32'd16);
      end
      if (done_o) dones++;
    end
    check("ovl done count", 32'(dones), 32'd2);

    // Reset in cycle 3 of SHIFT aborts with no done_o.
    @(negedge clk);
    Data_i = 26'h0000001; Shift_Value_i = 5'd2; Exp_i = 8'd9; start_i = 1'b1;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        check("rst Data_o", 32'(Data_o), 32'd0);
        check("rst Exp_o", 32'(Exp_o), 32'd0);
        check("rst flags", {28'd0, underflow_o, zero_o, busy_o, done_o}, 32'd0);
      end
      if (done_o) dones++;
    end
    check("rst no done", 32'(dones), 32'd0);

    run_op(26'h0000003, 5'd2, 8'd9, lat);
    check("post-rst latency", 32'(lat), 32'd6);
    check("post-rst Data_o", 32'(Data_o), 32'h000000C);
    check("post-rst Exp_o", 32'(Exp_o), 32'd7);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    check("rst vs start busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("rst vs start stays idle", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
